parking_capacity_tracker: RTL
=============================

# parking_capacity_tracker

Consumes the single-cycle `enter` / `exit` pulses from the parking-lot entrance FSM and maintains the lot occupancy. Occupancy is kept both as a binary count and as two BCD digits that feed the seven-segment display mux directly. The block enforces a capacity limit and raises full/empty status and sticky over/underflow error flags. It also drives a blink-enable that flashes the display while the lot is full.

## Interface
- `CAPACITY`, default 99: maximum occupancy; legal range 1..99.
- `BLINK_WIDTH`, default 26: width of the full-blink timer; blink half-period is 2^(BLINK_WIDTH-1) cycles.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enter`  in  1  single-cycle pulse: a car entered.
- `exit`  in  1  single-cycle pulse: a car exited.
- `clear_err`  in  1  level; clears the sticky error flags.
- `count`  out  7  binary occupancy, 0..CAPACITY.
- `hex0`  out  4  BCD ones digit of occupancy.
- `hex1`  out  4  BCD tens digit of occupancy.
- `full`  out  1  high when count == CAPACITY.
- `empty`  out  1  high when count == 0.
- `err_overflow`  out  1  sticky; set when an enter is rejected because the lot is full.
- `err_underflow`  out  1  sticky; set when an exit is rejected because the lot is empty.
- `disp_on`  out  1  display enable for the blink function; 1 = digits lit.

## Operation
- State is held in registers: `count`, `hex1:hex0`, the two error flags, the blink timer and `disp_on`. `full` and `empty` are combinational decodes of the registered `count`.
- Per-cycle event decode, using the register values present at that edge:
  - `enter` and `exit` both high: net zero. No change to count or digits, and no error flag is set, even if the lot is full or empty.
  - `enter` only, not full: count +1. BCD increment: ones 9 -> 0 with carry into tens, otherwise ones +1.
  - `enter` only, full: count unchanged; set `err_overflow`.
  - `exit` only, not empty: count -1. BCD decrement: ones 0 -> 9 with borrow from tens, otherwise ones -1.
  - `exit` only, empty: count unchanged; set `err_underflow`.
- BCD invariants:
  - `hex1*10 + hex0 == count` at all times.
  - Neither digit ever exceeds 9.
  - The digits are updated incrementally and never derived by division.
- Error flags:
  - Each flag is set by its event and held until `clear_err` is high at a clock edge.
  - If `clear_err` and a new error event occur in the same cycle, the error wins and the flag stays 1.
  - `clear_err` has no effect on count or digits.
- Blink timer (BLINK_WIDTH-bit free-running counter):
  - Counts only while `full`.
  - Is held at 0 while not full.
  - `disp_on` = 1 while not full. While full, `disp_on` = NOT timer MSB, so the first half-period after becoming full is lit.
- Pulses longer than one cycle are counted once per cycle high. Generating single-cycle pulses is the upstream FSM's responsibility.

## Timing
- Reset (asynchronous assert, synchronous release) drives:
  - count = 0, hex0 = hex1 = 0
  - empty = 1, full = 0
  - both error flags = 0
  - blink timer = 0, disp_on = 1
- Latency: an `enter` or `exit` sampled at edge N changes `count`, `hex0`, `hex1` and `full`/`empty` immediately after edge N. Error flags set after the same edge.
- Back-to-back pulses on consecutive cycles are each applied; there is no dead cycle.
- `disp_on` toggles every 2^(BLINK_WIDTH-1) cycles while full.
- `disp_on` returns to 1 on the first edge after `full` deasserts, with the timer cleared on that same edge.
- Reset asserted mid-operation clears all state asynchronously, including sticky errors and a running blink timer.

## Test plan
- Reset, then 10 `enter` pulses on consecutive cycles -> count = 10, hex1 = 1, hex0 = 0, empty = 0. Check the 9 -> 10 carry.
- CAPACITY = 12: 12 enters then 1 more -> count holds at 12, full = 1, err_overflow = 1. Assert clear_err for 1 cycle -> err_overflow = 0, count still 12.
- From 10, 1 `exit` -> count = 9, hex1 = 0, hex0 = 9 (borrow). From 0, 1 `exit` -> count stays 0, err_underflow = 1.
- `enter` and `exit` in the same cycle at count 0 and at count CAPACITY -> count unchanged, no error flag set.
- BLINK_WIDTH = 4, fill to CAPACITY:
  - disp_on is lit 8 cycles, dark 8 cycles, repeating.
  - One exit -> disp_on = 1 after the next edge and the timer resets.
- Mid-count (count = 37) with err_underflow set, pulse reset low asynchronously between edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/parking_capacity_tracker.sv
// Parking-lot occupancy tracker: binary and BCD occupancy, capacity limit,
// sticky over/underflow flags and a blink enable while the lot is full.
module parking_capacity_tracker #(
    parameter int CAPACITY    = 99,
    parameter int BLINK_WIDTH = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       exit,
    input  logic       clear_err,
    output logic [6:0] count,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic       full,
    output logic       empty,
    output logic       err_overflow,
    output logic       err_underflow,
    output logic       disp_on
);

    localparam logic [6:0] CAP = 7'(CAPACITY);

    logic                   do_inc;
    logic                   do_dec;
    logic                   ovf_evt;
    logic                   unf_evt;
    logic [BLINK_WIDTH-1:0] blink_timer;
    logic [BLINK_WIDTH-1:0] blink_next;

    assign full  = (count == CAP);
    assign empty = (count == 7'd0);

    // Simultaneous enter and exit cancel out, so they never raise an error.
    assign do_inc  = enter & ~exit & ~full;
    assign do_dec  = exit & ~enter & ~empty;
    assign ovf_evt = enter & ~exit & full;
    assign unf_evt = exit & ~enter & empty;

    assign blink_next = blink_timer + BLINK_WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 7'd0;
            hex0  <= 4'd0;
            hex1  <= 4'd0;
        end else if (do_inc) begin
            count <= count + 7'd1;
            if (hex0 == 4'd9) begin
                hex0 <= 4'd0;
                hex1 <= hex1 + 4'd1;
            end else begin
                hex0 <= hex0 + 4'd1;
            end
        end else if (do_dec) begin
            count <= count - 7'd1;
            if (hex0 == 4'd0) begin
                hex0 <= 4'd9;
                hex1 <= hex1 - 4'd1;
            end else begin
                hex0 <= hex0 - 4'd1;
            end
        end
    end

    // A new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= ovf_evt | (err_overflow & ~clear_err);
            err_underflow <= unf_evt | (err_underflow & ~clear_err);
        end
    end

    // disp_on tracks the inverted timer MSB so the first half-period is lit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_timer <= '0;
            disp_on     <= 1'b1;
        end else if (full) begin
            blink_timer <= blink_next;
            disp_on     <= ~blink_next[BLINK_WIDTH-1];
        end else begin
            blink_timer <= '0;
            disp_on     <= 1'b1;
        end
    end

endmodule
